// File: rtl/stage3_fetch_prefetch_buffer.sv
// Instruction prefetch queue between the instruction bus and the stage3 fetch stage.
// It reads sequential words ahead, queues {pc, instr} pairs and flushes on redirect.
module stage3_fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic                     CLK,
  input  logic                     nRST,
  output logic [31:0]              bus_addr,
  output logic                     bus_ren,
  input  logic [31:0]              bus_rdata,
  input  logic                     bus_busy,
  input  logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [31:0]              fetch_instr,
  output logic [31:0]              fetch_pc,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state, state_next;
  logic [31:0]   pf_pc, pf_pc_next;
  logic [31:0]   tgt_pc, tgt_pc_next;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count_next;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   redir_aligned;
  logic          done, push, pop;
  logic          unused_ok;

  assign redir_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_ok     = ^redirect_pc[1:0];

  assign bus_ren  = (state == REQ) || (state == DISCARD);
  assign bus_addr = pf_pc;
  assign done     = bus_ren && !bus_busy;
  assign push     = (state == REQ) && done && !redirect;

  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid && fetch_ready && !redirect;
  assign fetch_instr = fetch_valid ? instr_mem[head] : 32'h0;
  assign fetch_pc    = fetch_valid ? pc_mem[head]    : 32'h0;

  // In DISCARD pf_pc keeps the stale address on the bus; the new target waits in tgt_pc.
  always_comb begin
    state_next  = state;
    pf_pc_next  = pf_pc;
    tgt_pc_next = tgt_pc;
    count_next  = redirect ? '0 : count + CW'(push) - CW'(pop);
    case (state)
      IDLE: begin
        if (redirect) begin
          pf_pc_next = redir_aligned;
        end else if (!halt && (count < FULL)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          if (done) begin
            pf_pc_next = redir_aligned;
            state_next = IDLE;
          end else begin
            tgt_pc_next = redir_aligned;
            state_next  = DISCARD;
          end
        end else if (done) begin
          pf_pc_next = pf_pc + 32'd4;
          state_next = (!halt && (count_next < FULL)) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect) begin
          tgt_pc_next = redir_aligned;
        end
        if (done) begin
          pf_pc_next = tgt_pc_next;
          state_next = halt ? IDLE : REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      pf_pc  <= RESET_PC;
      tgt_pc <= RESET_PC;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      pf_pc  <= pf_pc_next;
      tgt_pc <= tgt_pc_next;
      count  <= count_next;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (pop)  head <= head + PW'(1);
        if (push) tail <= tail + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[tail]    <= pf_pc;
      instr_mem[tail] <= bus_rdata;
    end
  end

endmodule
